// File: rtl/leading_one_pkg.sv
// Shared constants and state encoding for the leading-one scanner and its encoder.
package leading_one_pkg;

   localparam int W    = 9;
   localparam int IDXW = 5;
   localparam logic [IDXW-1:0] IDX_NONE = 5'b11111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      EMPTY = 2'd2
   } state_t;

endpackage

// File: rtl/leading_one_scanner_if.sv
// Mask input and index output handshakes of the scanner; slave is the scanner side.
interface leading_one_scanner_if;

   logic                              in_valid;
   logic                              in_ready;
   logic [leading_one_pkg::W-1:0]     in_mask;
   logic                              out_valid;
   logic                              out_ready;
   logic [leading_one_pkg::IDXW-1:0]  out_index;
   logic                              out_last;
   logic [3:0]                        out_seq;

   modport master (
      output in_valid, in_mask, out_ready,
      input  in_ready, out_valid, out_index, out_last, out_seq
   );

   modport slave (
      input  in_valid, in_mask, out_ready,
      output in_ready, out_valid, out_index, out_last, out_seq
   );

endinterface

// File: rtl/leading_one_scanner_leading_one.sv
// Combinational 9-bit leading-one priority encoder; returns IDX_NONE for an all-zero mask.
module leading_one
   import leading_one_pkg::*;
(
   input  logic [W-1:0]    mask,
   output logic [IDXW-1:0] idx
);

   // Ascending scan: the last set bit seen, i.e. the highest one, wins.
   always_comb begin
      idx = IDX_NONE;
      for (int i = 0; i < W; i++) begin
         if (mask[i]) begin
            idx = IDXW'(i);
         end
      end
   end

endmodule

// File: rtl/leading_one_scanner.sv
// Emits the index of every set bit of an accepted mask, MSB first, one per handshake.
// Optional macro LEADING_ONE_SCANNER_EMPTY_TOKEN_EN: a zero mask yields one IDX_NONE beat.
module leading_one_scanner
   import leading_one_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   leading_one_scanner_if.slave  bus,
   output logic                  busy
);

   state_t         state_q, state_next;
   logic [W-1:0]   mask_q, mask_next;
   logic [3:0]     seq_q, seq_next;

   logic [IDXW-1:0] lead_idx;
   logic [W-1:0]    lead_onehot;
   logic [W-1:0]    mask_cleared;
   logic            last_beat;

   leading_one u_leading_one (
      .mask (mask_q),
      .idx  (lead_idx)
   );

   for (genvar gi = 0; gi < W; gi++) begin : g_onehot
      assign lead_onehot[gi] = (lead_idx == IDXW'(gi));
   end

   assign mask_cleared = mask_q & ~lead_onehot;
   assign last_beat    = (mask_cleared == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mask_q  <= '0;
         seq_q   <= '0;
      end else begin
         state_q <= state_next;
         mask_q  <= mask_next;
         seq_q   <= seq_next;
      end
   end

   // Outputs are a function of registers and flush only.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_index = IDX_NONE;
      bus.out_last  = 1'b0;
      bus.out_seq   = seq_q;
      busy          = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            bus.in_ready = !flush;
         end
         SCAN: begin
            bus.out_valid = 1'b1;
            bus.out_index = lead_idx;
            bus.out_last  = last_beat;
         end
         EMPTY: begin
            bus.out_valid = 1'b1;
            bus.out_last  = 1'b1;
         end
         default: begin
            bus.in_ready = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_next = state_q;
      mask_next  = mask_q;
      seq_next   = seq_q;
      if (flush) begin
         state_next = IDLE;
         mask_next  = '0;
         seq_next   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  mask_next = bus.in_mask;
                  seq_next  = '0;
                  if (bus.in_mask != '0) begin
                     state_next = SCAN;
                  end else begin
`ifdef LEADING_ONE_SCANNER_EMPTY_TOKEN_EN
                     state_next = EMPTY;
`else
                     state_next = IDLE;
`endif
                  end
               end
            end
            SCAN: begin
               if (bus.out_ready) begin
                  // seq restarts on the last beat so it never exceeds W-1.
                  if (last_beat) begin
                     state_next = IDLE;
                     mask_next  = '0;
                     seq_next   = '0;
                  end else begin
                     mask_next = mask_cleared;
                     seq_next  = seq_q + 4'd1;
                  end
               end
            end
            EMPTY: begin
               if (bus.out_ready) begin
                  state_next = IDLE;
                  mask_next  = '0;
                  seq_next   = '0;
               end
            end
            default: begin
               state_next = IDLE;
               mask_next  = '0;
               seq_next   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_leading_one_scanner.sv
// Scoreboard bench for leading_one_scanner; zero-mask test follows LEADING_ONE_SCANNER_EMPTY_TOKEN_EN.
module tb_leading_one_scanner;

   typedef struct packed {
      logic [4:0] idx;
      logic       last;
      logic [3:0] seq;
   } beat_t;

   logic clk;
   logic rst_n;
   logic flush;
   logic busy;

   leading_one_scanner_if bus ();

   leading_one_scanner dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave),
      .busy  (busy)
   );

   beat_t exp_q[$];
   int    total;
   int    bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: walk the mask from the MSB down and predict every beat.
   task automatic push_mask(input logic [8:0] m);
      logic [8:0] rem;
      logic [3:0] s;
      rem = m;
      s   = 4'd0;
      for (int i = 8; i >= 0; i--) begin
         if (rem[i]) begin
            rem[i] = 1'b0;
            exp_q.push_back('{idx: 5'(i), last: (rem == 9'd0), seq: s});
            s = s + 4'd1;
         end
      end
   endtask

   task automatic monitor_loop();
      beat_t got, want;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready) begin
            got = '{idx: bus.out_index, last: bus.out_last, seq: bus.out_seq};
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL beat_unexpected: got idx=%0d last=%0d seq=%0d, none expected",
                        got.idx, got.last, got.seq);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  bad++;
                  $display("FAIL beat: got idx=%0d last=%0d seq=%0d, want idx=%0d last=%0d seq=%0d",
                           got.idx, got.last, got.seq, want.idx, want.last, want.seq);
               end else begin
                  $display("beat idx=%0d last=%0d seq=%0d ok", got.idx, got.last, got.seq);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || bus.out_index !== 5'd31 || bus.out_last !== 1'b0 ||
          bus.out_seq !== 4'd0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_state: got valid=%b idx=%0d last=%b seq=%0d busy=%b in_ready=%b, want 0 31 0 0 0 1",
                  bus.out_valid, bus.out_index, bus.out_last, bus.out_seq, busy, bus.in_ready);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bus.out_ready = 1'b1;
      bus.in_mask   = 9'b1_0010_0001;
      bus.in_valid  = 1'b1;
      push_mask(9'b1_0010_0001);
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL basic_in_ready: got %b want 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== 5'd8) begin
         bad++;
         $display("FAIL basic_first_beat: got valid=%b idx=%0d want 1 8", bus.out_valid, bus.out_index);
      end
      tick();
      tick();
      total++;
      if (bus.out_index !== 5'd0 || bus.out_last !== 1'b1) begin
         bad++;
         $display("FAIL basic_third_beat: got idx=%0d last=%b want 0 1", bus.out_index, bus.out_last);
      end
      tick();
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL basic_done: got in_ready=%b valid=%b busy=%b pending=%0d want 1 0 0 0",
                  bus.in_ready, bus.out_valid, busy, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      bus.in_mask   = 9'b0_0000_0110;
      bus.in_valid  = 1'b1;
      push_mask(9'b0_0000_0110);
      tick();
      bus.in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_index !== 5'd2 || bus.out_seq !== 4'd0 || bus.out_last !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold[%0d]: got valid=%b idx=%0d seq=%0d last=%b want 1 2 0 0",
                     c, bus.out_valid, bus.out_index, bus.out_seq, bus.out_last);
         end
         if (c < 2) tick();
      end
      bus.out_ready = 1'b1;
      tick();
      total++;
      if (bus.out_index !== 5'd1 || bus.out_last !== 1'b1 || bus.out_seq !== 4'd1) begin
         bad++;
         $display("FAIL stall_second: got idx=%0d last=%b seq=%0d want 1 1 1",
                  bus.out_index, bus.out_last, bus.out_seq);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL stall_done: got valid=%b pending=%0d want 0 0", bus.out_valid, exp_q.size());
      end
   endtask

   task automatic test_zero_mask();
      bus.out_ready = 1'b1;
      bus.in_mask   = 9'd0;
      bus.in_valid  = 1'b1;
`ifdef LEADING_ONE_SCANNER_EMPTY_TOKEN_EN
      exp_q.push_back('{idx: 5'd31, last: 1'b1, seq: 4'd0});
      tick();
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== 5'd31 || bus.out_last !== 1'b1) begin
         bad++;
         $display("FAIL empty_token: got valid=%b idx=%0d last=%b want 1 31 1",
                  bus.out_valid, bus.out_index, bus.out_last);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL empty_done: got valid=%b pending=%0d want 0 0", bus.out_valid, exp_q.size());
      end
`else
      tick();
      bus.in_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         total++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_drop[%0d]: got valid=%b in_ready=%b busy=%b want 0 1 0",
                     c, bus.out_valid, bus.in_ready, busy);
         end
         tick();
      end
`endif
   endtask

   task automatic test_flush_mid();
      bus.out_ready = 1'b1;
      bus.in_mask   = 9'h1FF;
      bus.in_valid  = 1'b1;
      exp_q.push_back('{idx: 5'd8, last: 1'b0, seq: 4'd0});
      exp_q.push_back('{idx: 5'd7, last: 1'b0, seq: 4'd1});
      exp_q.push_back('{idx: 5'd6, last: 1'b0, seq: 4'd2});
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== 5'd6) begin
         bad++;
         $display("FAIL flush_third_beat: got valid=%b idx=%0d want 1 6", bus.out_valid, bus.out_index);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL flush_after: got valid=%b busy=%b in_ready=%b pending=%0d want 0 0 1 0",
                  bus.out_valid, busy, bus.in_ready, exp_q.size());
      end
      tick();
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b1;
      bus.in_mask   = 9'h1FF;
      bus.in_valid  = 1'b1;
      exp_q.push_back('{idx: 5'd8, last: 1'b0, seq: 4'd0});
      exp_q.push_back('{idx: 5'd7, last: 1'b0, seq: 4'd1});
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_index !== 5'd31 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL async_reset: got valid=%b busy=%b idx=%0d pending=%0d want 0 0 31 0",
                  bus.out_valid, busy, bus.out_index, exp_q.size());
      end
      tick();
      rst_n = 1'b1;
      tick();
      bus.in_mask  = 9'b0_0000_0001;
      bus.in_valid = 1'b1;
      push_mask(9'b0_0000_0001);
      tick();
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== 5'd0 || bus.out_last !== 1'b1 || bus.out_seq !== 4'd0) begin
         bad++;
         $display("FAIL post_reset_beat: got valid=%b idx=%0d last=%b seq=%0d want 1 0 1 0",
                  bus.out_valid, bus.out_index, bus.out_last, bus.out_seq);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL post_reset_done: got valid=%b pending=%0d want 0 0", bus.out_valid, exp_q.size());
      end
   endtask

   task automatic test_flush_idle();
      flush        = 1'b1;
      bus.in_mask  = 9'b0_0000_0101;
      bus.in_valid = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL flush_idle_ready: got %b want 0", bus.in_ready);
      end
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         total++;
         if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_noaccept[%0d]: got valid=%b busy=%b want 0 0", c, bus.out_valid, busy);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      bus.in_mask   = 9'b0_0000_0011;
      bus.in_valid  = 1'b1;
      push_mask(9'b0_0000_0011);
      tick();
      bus.in_mask = 9'b1_0100_0000;
      push_mask(9'b1_0100_0000);
      for (int c = 0; c < 2; c++) begin
         total++;
         if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_blocked[%0d]: got in_ready=%b want 0", c, bus.in_ready);
         end
         tick();
      end
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_gap: got in_ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid);
      end
      tick();
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== 5'd8) begin
         bad++;
         $display("FAIL b2b_second_mask: got valid=%b idx=%0d want 1 8", bus.out_valid, bus.out_index);
      end
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
      tick();
      total++;
      if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_drain: got pending=%0d valid=%b want 0 0", exp_q.size(), bus.out_valid);
      end
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_mask   = '0;
      bus.out_ready = 1'b0;
      fork
         monitor_loop();
      join_none
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_mask();
      test_flush_mid();
      test_reset_mid();
      test_flush_idle();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/leading_one_scanner.md
# leading_one_scanner

Sequential scanner around the 9-bit leading-one priority encoder. It accepts a bit mask over a valid/ready handshake and emits the index of every set bit, MSB first, one per output handshake. Each emitted bit is cleared until the mask is exhausted. It sits between a requester-mask producer (interrupt/request collector) and a consumer that services one index at a time.

## Interface
- W, 9: mask width; fixed at 9 for this revision.
- IDXW, 5: index width; index 5'b11111 (IDX_NONE) means "no bit set".
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset (one clock; reset asserts asynchronously).
- flush  input  1  synchronous abort of the current mask.
- in_valid  input  1  in_mask is valid.
- in_ready  output  1  scanner can accept a mask.
- in_mask  input  W  mask to scan.
- out_valid  output  1  out_index/out_last/out_seq are valid.
- out_ready  input  1  consumer takes the current beat.
- out_index  output  IDXW  index of the highest remaining set bit.
- out_last  output  1  current beat is the last one for this mask.
- out_seq  output  4  beat number within the current mask, starting at 0.
- busy  output  1  a mask is held (state != IDLE).

## Operation
- Registers: state, mask_q[W-1:0], seq_q[3:0].
- States:
  - IDLE: in_ready = !flush. On in_valid && in_ready, load mask_q = in_mask and seq_q = 0. A nonzero mask moves to SCAN. A zero mask is handled per Configuration.
  - SCAN: out_valid = 1; out_index = leading-one(mask_q); out_last = (mask_q with bit out_index cleared) == 0; out_seq = seq_q.
    - On out_valid && out_ready: clear bit out_index in mask_q and increment seq_q. If out_last, go to IDLE with mask_q = 0.
  - EMPTY (macro only): out_valid = 1, out_index = IDX_NONE, out_last = 1, out_seq = 0. Go to IDLE on out_ready.
- Outputs depend only on registers and flush. There is no combinational path from in_* or out_ready to out_*.
- Back-to-back: in_ready is 0 outside IDLE, so a new mask is not accepted in the cycle of the last output handshake.
- flush (any state): next state IDLE, mask_q = 0, seq_q = 0.
  - flush has priority over a simultaneous input accept (in_ready is forced 0).
  - A beat that handshakes in the same cycle as flush counts as delivered. No further beats follow.
- Reset mid-operation: all state is cleared immediately and the mask is discarded.
- Reset values: state IDLE, mask_q 0, seq_q 0. Resulting outputs: out_valid 0, out_index 5'b11111, out_last 0, out_seq 0, busy 0, in_ready = !flush.

## Timing
- Mask accepted at edge N: first out_valid is in cycle N+1.
- k set bits with out_ready held high: k beats in cycles N+1 .. N+k. in_ready returns in cycle N+k+1. One mask is processed per k+1 cycles.
- Under backpressure, out_index/out_last/out_seq stay stable while out_valid && !out_ready. out_valid never drops without a handshake, except on flush or reset.
- seq_q never exceeds 8.

## Configuration
- LEADING_ONE_SCANNER_EMPTY_TOKEN_EN:
  - Defined: a zero mask enters EMPTY and produces exactly one beat (index 5'b11111, last=1, seq=0).
  - Undefined: a zero mask is accepted and silently dropped. State stays IDLE, no out_valid, and in_ready stays 1.

## Structure
- Shared package leading_one_pkg holds:
  - W = 9, IDXW = 5, IDX_NONE = 5'b11111.
  - State encoding: IDLE = 2'd0, SCAN = 2'd1, EMPTY = 2'd2.
- One sub-module: leading_one, the combinational 9-bit priority encoder returning 5'b11111 on zero. It is instantiated on mask_q. The scanner contains no duplicate priority logic.

## Test plan
- Mask 9'b1_0010_0001, out_ready=1 -> beats at cycles 1–3 with index 8,5,0; seq 0,1,2; out_last only on index 0; in_ready=1 at cycle 4.
- Mask 9'b0_0000_0110, out_ready low for 3 cycles -> index 2, seq 0 held stable for 3 cycles, then beats 2 and 1, last on 1.
- Mask 0 -> macro defined: one beat with index 31, last=1. Undefined: no out_valid within 10 cycles and in_ready stays 1.
- Mask 9'h1FF, flush asserted with the 3rd beat's handshake -> 3 beats delivered (8,7,6), out_valid=0 next cycle, busy=0, in_ready=1.
- Mask 9'h1FF, rst_n low mid-scan -> out_valid=0, busy=0, out_index=31 with no clock edge. After release, a new mask 9'b0_0000_0001 yields a single beat: index 0, last=1, seq=0.
- flush=1 with in_valid=1 in IDLE -> in_ready=0, mask not accepted, no out_valid afterwards.
